ram_preload_mux: RTL and testbench

RAM_PRELOAD_MUX -- requirements
Module: ram_preload_mux

---
 rtl/ram_preload_mux.sv | 155 +++++++++++++++
 tb/tb_ram_preload_mux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_preload_mux.sv
// Arbitrates one RAM port across three phases: external preload, CGRA run-time
// access, and a handshaked result dump. Rejected addresses feed a saturating error counter.
module ram_preload_mux #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clock,
   input  logic             sync_reset,
   input  logic             load_start,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [31:0]      load_addr,
   input  logic [31:0]      load_data,
   input  logic             load_last,
   input  logic [31:0]      cgra_addr,
   input  logic [31:0]      cgra_data_in,
   input  logic             cgra_w_rq,
   output logic [31:0]      cgra_data_out,
   output logic [31:0]      ram_addr,
   output logic [31:0]      ram_data_in,
   output logic             ram_w_rq,
   input  logic [31:0]      ram_data_out,
   output logic             run_active,
   input  logic             dump_start,
   input  logic [31:0]      dump_base,
   input  logic [15:0]      dump_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             dump_done,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      DUMP_RD,
      DUMP_WAIT,
      DUMP_OUT
   } state_t;

   // 33 bits so DEPTH values near 2^30 still produce an exact byte limit
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

   state_t      state, state_next;
   logic [31:0] cur_addr;
   logic [15:0] remaining;
   logic        load_accept;
   logic        load_ok;

   function automatic logic in_range(input logic [31:0] a);
      return {1'b0, a} < ADDR_LIMIT;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   assign load_ready  = (state == LOAD) && !sync_reset;
   assign load_accept = load_valid && load_ready;
   assign load_ok     = load_accept && (load_addr[1:0] == 2'b00) && in_range(load_addr);
   assign run_active  = (state == RUN);

   always_ff @(posedge clock) begin
      if (sync_reset) state <= IDLE;
      else            state <= state_next;
   end

   always_comb begin
      state_next    = state;
      ram_addr      = '0;
      ram_data_in   = '0;
      ram_w_rq      = 1'b0;
      cgra_data_out = '0;
      case (state)
         IDLE: begin
            if (load_start) state_next = LOAD;
         end
         LOAD: begin
            if (load_ok) begin
               ram_addr    = load_addr;
               ram_data_in = load_data;
               ram_w_rq    = 1'b1;
            end
            if (load_accept && load_last) state_next = RUN;
         end
         RUN: begin
            ram_addr      = cgra_addr;
            ram_data_in   = cgra_data_in;
            ram_w_rq      = cgra_w_rq && !sync_reset;
            cgra_data_out = ram_data_out;
            if (dump_start && (dump_count != 16'd0)) state_next = DUMP_RD;
         end
         DUMP_RD: begin
            ram_addr   = cur_addr;
            state_next = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            state_next = DUMP_OUT;
         end
         DUMP_OUT: begin
            if (out_ready) state_next = (remaining == 16'd1) ? IDLE : DUMP_RD;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (sync_reset) begin
         cur_addr  <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         dump_done <= 1'b0;
         err_count <= '0;
      end else begin
         dump_done <= 1'b0;
         case (state)
            LOAD: begin
               if (load_accept && !load_ok) err_count <= sat_inc(err_count);
            end
            RUN: begin
               if (dump_start) begin
                  if (dump_count == 16'd0) begin
                     dump_done <= 1'b1;
                  end else begin
                     cur_addr  <= dump_base;
                     remaining <= dump_count;
                  end
               end
            end
            DUMP_WAIT: begin
               out_valid <= 1'b1;
               if (in_range(cur_addr)) begin
                  out_data <= ram_data_out;
               end else begin
                  out_data  <= '0;
                  err_count <= sat_inc(err_count);
               end
            end
            DUMP_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) dump_done <= 1'b1;
                  else                    cur_addr  <= cur_addr + 32'd4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_preload_mux.sv
// Scoreboarded bench for ram_preload_mux: a behavioural RAM, directed load/run/dump
// scenarios, and a monitor that pops expected dump words on each accepted handshake.
module tb_ram_preload_mux;

   logic        clock = 1'b0;
   logic        sync_reset;
   logic        load_start, load_valid, load_ready, load_last;
   logic [31:0] load_addr, load_data;
   logic [31:0] cgra_addr, cgra_data_in, cgra_data_out;
   logic        cgra_w_rq;
   logic [31:0] ram_addr, ram_data_in, ram_data_out;
   logic        ram_w_rq;
   logic        run_active;
   logic        dump_start;
   logic [31:0] dump_base;
   logic [15:0] dump_count;
   logic        out_valid, out_ready, dump_done;
   logic [31:0] out_data;
   logic [7:0]  err_count;

   logic [31:0] mem [0:1023];
   int          wr_count = 0;
   int          tests = 0;
   int          failed = 0;
   int          done_pulses = 0;
   logic [31:0] exp_q [$];
   logic [31:0] held_data;
   logic        held_valid = 1'b0;

   always #5 clock = ~clock;

   ram_preload_mux #(.DEPTH(1024), .ERR_W(8)) dut (
      .clock(clock), .sync_reset(sync_reset),
      .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
      .cgra_addr(cgra_addr), .cgra_data_in(cgra_data_in), .cgra_w_rq(cgra_w_rq),
      .cgra_data_out(cgra_data_out),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_w_rq(ram_w_rq),
      .ram_data_out(ram_data_out), .run_active(run_active),
      .dump_start(dump_start), .dump_base(dump_base), .dump_count(dump_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .dump_done(dump_done), .err_count(err_count)
   );

   // Behavioural RAM: registered read, out-of-range reads return a marker value
   always @(posedge clock) begin
      if (ram_w_rq) begin
         wr_count <= wr_count + 1;
         if (ram_addr < 32'h1000) mem[ram_addr[11:2]] <= ram_data_in;
      end
      ram_data_out <= (ram_addr < 32'h1000) ? mem[ram_addr[11:2]] : 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (dump_done) done_pulses++;
      if (out_valid) begin
         if (held_valid) check("dump_stall_stable", out_data, held_data);
         if (out_ready) begin
            if (exp_q.size() == 0) check("dump_unexpected_word", out_data, 32'hFFFF_FFFF);
            else                   check("dump_word", out_data, exp_q.pop_front());
            held_valid = 1'b0;
         end else begin
            held_data  = out_data;
            held_valid = 1'b1;
         end
      end else begin
         held_valid = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] d,
                            input logic l, input logic exp_wr);
      load_valid = 1'b1; load_addr = a; load_data = d; load_last = l;
      @(negedge clock);
      check("load_ready", 32'(load_ready), 32'd1);
      check("load_wr_rq", 32'(ram_w_rq), 32'(exp_wr));
      if (exp_wr) begin
         check("load_ram_addr", ram_addr, a);
         check("load_ram_data", ram_data_in, d);
      end
      tick;
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic run_dump(input logic [31:0] base, input logic [15:0] cnt, input bit toggle);
      int n = 0;
      int start_pulses;
      dump_base = base; dump_count = cnt; dump_start = 1'b1;
      tick;
      dump_start = 1'b0;
      start_pulses = done_pulses;
      while (!dump_done && n < 200) begin
         out_ready = toggle ? ~out_ready : 1'b1;
         tick;
         n++;
      end
      out_ready = 1'b0;
      check("dump_timeout", 32'(n < 200), 32'd1);
      @(negedge clock);
      tick;
      check("dump_done_width", 32'(dump_done), 32'd0);
      check("dump_done_pulses", 32'(done_pulses - start_pulses), 32'd1);
      check("dump_queue_empty", 32'(exp_q.size()), 32'd0);
      check("dump_back_to_idle", 32'(run_active), 32'd0);
   endtask

   initial begin
      int wr0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      sync_reset = 1'b1; load_start = 1'b0; load_valid = 1'b1; load_last = 1'b0;
      load_addr = '0; load_data = '0; cgra_addr = '0; cgra_data_in = '0; cgra_w_rq = 1'b0;
      dump_start = 1'b0; dump_base = '0; dump_count = '0; out_ready = 1'b0;
      tick;
      @(negedge clock);
      check("reset_ram_w_rq", 32'(ram_w_rq), 32'd0);
      check("reset_load_ready", 32'(load_ready), 32'd0);
      tick;
      sync_reset = 1'b0; load_valid = 1'b0;
      check("reset_run_active", 32'(run_active), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_err_count", 32'(err_count), 32'd0);
      check("reset_dump_done", 32'(dump_done), 32'd0);

      // Preload with two rejected words and an upper-boundary word
      wr0 = wr_count;
      load_start = 1'b1; tick; load_start = 1'b0;
      load_word(32'h0000_0000, 32'd16,          1'b0, 1'b1);
      load_word(32'h0000_0C02, 32'h0000_AAAA,   1'b0, 1'b0);
      load_word(32'h0000_1000, 32'h0000_BBBB,   1'b0, 1'b0);
      load_word(32'h0000_0FFC, 32'h1234_5678,   1'b0, 1'b1);
      load_word(32'h0000_0C00, 32'h0001_0000,   1'b1, 1'b1);
      check("load_run_active", 32'(run_active), 32'd1);
      check("load_err_count", 32'(err_count), 32'd2);
      check("load_mem_0", mem[0], 32'd16);
      check("load_mem_300", mem[10'h300], 32'h0001_0000);
      check("load_mem_3ff", mem[10'h3FF], 32'h1234_5678);
      check("load_write_count", 32'(wr_count - wr0), 32'd3);

      load_start = 1'b1; tick; load_start = 1'b0;
      check("load_start_in_run", 32'(run_active), 32'd1);
      check("load_ready_in_run", 32'(load_ready), 32'd0);

      // CGRA pass-through write then read-back
      cgra_addr = 32'h0000_0E04; cgra_data_in = 32'h7FFF_0000; cgra_w_rq = 1'b1;
      @(negedge clock);
      check("cgra_wr_rq", 32'(ram_w_rq), 32'd1);
      check("cgra_wr_addr", ram_addr, 32'h0000_0E04);
      tick;
      cgra_w_rq = 1'b0;
      tick;
      @(negedge clock);
      check("cgra_mem_381", mem[10'h381], 32'h7FFF_0000);
      check("cgra_read_data", cgra_data_out, 32'h7FFF_0000);
      tick;
      for (int i = 1; i < 4; i++) begin
         cgra_addr = 32'h0000_0C00 + 32'(4 * i);
         cgra_data_in = 32'h1111_1111 * 32'(i);
         cgra_w_rq = 1'b1;
         tick;
      end
      cgra_w_rq = 1'b0; cgra_addr = '0; cgra_data_in = '0;

      exp_q.push_back(32'h0001_0000);
      exp_q.push_back(32'h1111_1111);
      exp_q.push_back(32'h2222_2222);
      exp_q.push_back(32'h3333_3333);
      run_dump(32'h0000_0C00, 16'd4, 1'b1);
      check("dump_err_count", 32'(err_count), 32'd2);

      // CGRA access outside RUN is ignored and the port idles at zero
      cgra_addr = 32'h0000_0E04; cgra_data_in = 32'h0000_0001; cgra_w_rq = 1'b1;
      @(negedge clock);
      check("idle_cgra_wr_rq", 32'(ram_w_rq), 32'd0);
      check("idle_ram_addr", ram_addr, 32'd0);
      check("idle_cgra_data_out", cgra_data_out, 32'd0);
      tick;
      cgra_w_rq = 1'b0; cgra_addr = '0; cgra_data_in = '0;
      check("idle_mem_381", mem[10'h381], 32'h7FFF_0000);

      // Rejected last word still ends the session
      wr0 = wr_count;
      load_start = 1'b1; tick; load_start = 1'b0;
      load_word(32'h0000_1001, 32'h0000_0005, 1'b1, 1'b0);
      check("badlast_run_active", 32'(run_active), 32'd1);
      check("badlast_err_count", 32'(err_count), 32'd3);
      check("badlast_no_write", 32'(wr_count - wr0), 32'd0);

      dump_count = 16'd0; dump_start = 1'b1; tick; dump_start = 1'b0;
      @(negedge clock);
      check("zero_dump_done", 32'(dump_done), 32'd1);
      check("zero_dump_run_active", 32'(run_active), 32'd1);
      tick;
      check("zero_dump_done_clear", 32'(dump_done), 32'd0);

      // Dump crossing the top of RAM: second word is out of range
      exp_q.push_back(32'h1234_5678);
      exp_q.push_back(32'h0000_0000);
      run_dump(32'h0000_0FFC, 16'd2, 1'b0);
      check("oob_err_count", 32'(err_count), 32'd4);

      dump_base = 32'h0000_0C00; dump_count = 16'd1; dump_start = 1'b1;
      tick; dump_start = 1'b0;
      tick; tick; tick;
      check("idle_dump_ignored_valid", 32'(out_valid), 32'd0);
      check("idle_dump_ignored_run", 32'(run_active), 32'd0);

      // Reset during LOAD with a valid word pending
      wr0 = wr_count;
      load_start = 1'b1; tick; load_start = 1'b0;
      load_valid = 1'b1; load_addr = 32'h0000_0010; load_data = 32'd9; sync_reset = 1'b1;
      @(negedge clock);
      check("rst_load_wr_rq", 32'(ram_w_rq), 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd0);
      tick;
      sync_reset = 1'b0; load_valid = 1'b0;
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_load_ready_idle", 32'(load_ready), 32'd0);
      check("rst_no_write", 32'(wr_count - wr0), 32'd0);
      check("rst_mem_4", mem[4], 32'd0);
      load_start = 1'b1; tick; load_start = 1'b0;
      check("rst_idle_accepts_start", 32'(load_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
